// File: rtl/fp32_addsub_seq_pkg.sv
// Shared FP32 field layout, special constants and sequencer state encoding
// for the multi-cycle add/subtract unit.
package fp32_addsub_seq_pkg;
  localparam int          SIGN_BIT = 31;
  localparam int          EXP_MSB  = 30;
  localparam int          EXP_LSB  = 23;
  localparam int          FRAC_MSB = 22;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam logic [7:0]  INF_EXP  = 8'hFF;
  localparam int          EXP_BIAS = 127;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_EXP   = 3'd1,
    S_ALIGN = 3'd2,
    S_ADD   = 3'd3,
    S_NORM  = 3'd4,
    S_DONE  = 3'd5
  } state_e;
endpackage

// File: rtl/fp32_addsub_seq_prims.sv
// Shared ripple add/subtract cells: s = a + (b ^ {cin}) + cin.
module Adder_Subtractor8 (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       cin_i,
  output logic [7:0] s_o
);
  assign s_o = a_i + (b_i ^ {8{cin_i}}) + {7'd0, cin_i};
endmodule

module Adder_Subtractor25 (
  input  logic [24:0] a_i,
  input  logic [24:0] b_i,
  input  logic        cin_i,
  output logic [24:0] s_o
);
  assign s_o = a_i + (b_i ^ {25{cin_i}}) + {24'd0, cin_i};
endmodule

// File: rtl/fp32_addsub_seq_special.sv
// Combinational NaN/inf/zero classification of the operand pair (b already
// carries its effective sign) and the short-circuit result for those cases.
module fp32_special_detect
  import fp32_addsub_seq_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        special_o,
  output logic [31:0] res_o
);
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  assign a_nan  = (a_i[EXP_MSB:EXP_LSB] == INF_EXP) &&  (|a_i[FRAC_MSB:0]);
  assign b_nan  = (b_i[EXP_MSB:EXP_LSB] == INF_EXP) &&  (|b_i[FRAC_MSB:0]);
  assign a_inf  = (a_i[EXP_MSB:EXP_LSB] == INF_EXP) && !(|a_i[FRAC_MSB:0]);
  assign b_inf  = (b_i[EXP_MSB:EXP_LSB] == INF_EXP) && !(|b_i[FRAC_MSB:0]);
  // Denormals collapse to zero here, so they never reach the datapath.
  assign a_zero = (a_i[EXP_MSB:EXP_LSB] == 8'd0);
  assign b_zero = (b_i[EXP_MSB:EXP_LSB] == 8'd0);

  always_comb begin
    special_o = 1'b1;
    res_o     = '0;
    if (a_nan || b_nan || (a_inf && b_inf && (a_i[SIGN_BIT] != b_i[SIGN_BIT])))
      res_o = QNAN;
    else if (a_inf)             res_o = a_i;
    else if (b_inf)             res_o = b_i;
    else if (a_zero && b_zero)  res_o = {a_i[SIGN_BIT] & b_i[SIGN_BIT], 31'd0};
    else if (a_zero)            res_o = b_i;
    else if (b_zero)            res_o = a_i;
    else                        special_o = 1'b0;
  end
endmodule

// File: rtl/fp32_addsub_seq.sv
// Multi-cycle FP32 add/subtract: one shared 8-bit exponent adder and one
// 25-bit mantissa adder sequenced through order/align/add/normalise steps.
module fp32_addsub_seq
  import fp32_addsub_seq_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        busy
);
  localparam int M_W = MAN_W + 2;

  state_e             state_q, state_d;
  logic [31:0]        a_q, a_d, b_q, b_d, res_q, res_d;
  logic [EXP_W-1:0]   er_q, er_d, diff_q, diff_d;
  logic               sign_q, sign_d, eff_sub_q, eff_sub_d;
  logic [M_W-1:0]     ml_q, ml_d, ms_q, ms_d;

  logic [31:0]        b_eff, spec_res, l_op, s_op;
  logic               spec, a_is_l;
  logic [EXP_W-1:0]   ex_a, ex_b, ex_s;
  logic               ex_sub;
  logic [M_W-1:0]     sum;

  assign b_eff = {b[SIGN_BIT] ^ sub, b[30:0]};

  fp32_special_detect u_spec (.a_i(a), .b_i(b_eff), .special_o(spec), .res_o(spec_res));

  // Ties keep A as the larger operand.
  assign a_is_l = (a_q[30:0] >= b_q[30:0]);
  assign l_op   = a_is_l ? a_q : b_q;
  assign s_op   = a_is_l ? b_q : a_q;

  // Exponent cell: eL-eS in EXP, er+1 in ADD, er-1 in NORM.
  always_comb begin
    ex_a   = er_q;
    ex_b   = 8'd1;
    ex_sub = 1'b1;
    if (state_q == S_EXP) begin
      ex_a = l_op[EXP_MSB:EXP_LSB];
      ex_b = s_op[EXP_MSB:EXP_LSB];
    end else if (state_q == S_ADD) begin
      ex_sub = 1'b0;
    end
  end

  Adder_Subtractor8  u_exp (.a_i(ex_a), .b_i(ex_b), .cin_i(ex_sub),    .s_o(ex_s));
  Adder_Subtractor25 u_man (.a_i(ml_q), .b_i(ms_q), .cin_i(eff_sub_q), .s_o(sum));

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    er_d      = er_q;
    diff_d    = diff_q;
    sign_d    = sign_q;
    eff_sub_d = eff_sub_q;
    ml_d      = ml_q;
    ms_d      = ms_q;
    case (state_q)
      S_IDLE: if (in_valid) begin
        a_d = a;
        b_d = b_eff;
        if (spec) begin
          res_d   = spec_res;
          state_d = S_DONE;
        end else begin
          state_d = S_EXP;
        end
      end
      S_EXP: begin
        er_d      = l_op[EXP_MSB:EXP_LSB];
        diff_d    = ex_s;
        sign_d    = l_op[SIGN_BIT];
        eff_sub_d = a_q[SIGN_BIT] ^ b_q[SIGN_BIT];
        ml_d      = {2'b01, l_op[FRAC_MSB:0]};
        ms_d      = {2'b01, s_op[FRAC_MSB:0]};
        state_d   = S_ALIGN;
      end
      S_ALIGN: begin
        ms_d    = (diff_q >= EXP_W'(M_W)) ? '0 : (ms_q >> diff_q);
        state_d = S_ADD;
      end
      S_ADD: begin
        if (sum == '0) begin
          res_d   = '0;
          state_d = S_DONE;
        end else if (sum[M_W-1]) begin
          ml_d = sum >> 1;
          er_d = ex_s;
          if (ex_s == INF_EXP) begin
            res_d   = {sign_q, INF_EXP, {MAN_W{1'b0}}};
            state_d = S_DONE;
          end else begin
            state_d = S_NORM;
          end
        end else begin
          ml_d    = sum;
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        if (ml_q[MAN_W]) begin
          res_d   = {sign_q, er_q, ml_q[FRAC_MSB:0]};
          state_d = S_DONE;
        end else if (er_q == 8'd1) begin
          res_d   = {sign_q, 31'd0};
          state_d = S_DONE;
        end else begin
          ml_d = ml_q << 1;
          er_d = ex_s;
        end
      end
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      er_q      <= '0;
      diff_q    <= '0;
      sign_q    <= 1'b0;
      eff_sub_q <= 1'b0;
      ml_q      <= '0;
      ms_q      <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      er_q      <= er_d;
      diff_q    <= diff_d;
      sign_q    <= sign_d;
      eff_sub_q <= eff_sub_d;
      ml_q      <= ml_d;
      ms_q      <= ms_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign result    = res_q;
endmodule

// File: tb/tb_fp32_addsub_seq.sv
// Directed bench for fp32_addsub_seq: expected results/latencies go into a
// scoreboard queue when an operation is driven and are popped at out_valid.
module tb_fp32_addsub_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        busy;

  int checks = 0;
  int failures = 0;
  logic [31:0] q_res[$];
  int          q_lat[$];

  fp32_addsub_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one operation, wait for the result, optionally stall the consumer
  // for 'hold' cycles while offering a competing operand pair.
  task automatic do_op(input logic [31:0] aa, input logic [31:0] bb, input logic s,
                       input logic [31:0] exp_res, input int exp_lat, input int hold);
    int n;
    logic [31:0] e_res;
    int e_lat;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk("in_ready_before", {31'd0, in_ready}, 32'd1);
    q_res.push_back(exp_res);
    q_lat.push_back(exp_lat);
    a = aa; b = bb; sub = s; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("in_ready_busy", {30'd0, in_ready, busy}, 32'd1);
    n = 0;
    while (out_valid !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    e_res = q_res.pop_front();
    e_lat = q_lat.pop_front();
    chk("latency", n, e_lat);
    chk("result", result, e_res);
    if (hold > 0) begin
      a = 32'h7F80_0000; b = 32'h7F80_0000; sub = 1'b0; in_valid = 1'b1;
      repeat (hold) @(negedge clk);
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_result", result, e_res);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("back_to_idle", {30'd0, in_ready, out_valid}, 32'd2);
  endtask

  initial begin
    #12;
    @(negedge clk);
    chk("rst_state", {29'd0, in_ready, out_valid, busy}, 32'd4);
    chk("rst_result", result, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 4, 0);
    do_op(32'h3FC0_0000, 32'h3F80_0000, 1'b1, 32'h3F00_0000, 5, 0);
    do_op(32'h3F80_0000, 32'h3080_0000, 1'b0, 32'h3F80_0000, 4, 0);
    do_op(32'h4049_0FDB, 32'h4049_0FDB, 1'b1, 32'h0000_0000, 3, 0);
    do_op(32'h7F80_0000, 32'hFF80_0000, 1'b0, 32'h7FC0_0000, 0, 0);
    do_op(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 3, 0);
    do_op(32'h0000_0000, 32'h3F80_0000, 1'b1, 32'hBF80_0000, 0, 0);
    do_op(32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, 4, 10);
    do_op(32'hBF80_0000, 32'h3F00_0000, 1'b0, 32'hBF00_0000, 5, 0);
    do_op(32'h00C0_0000, 32'h0080_0000, 1'b1, 32'h0000_0000, 4, 0);
    do_op(32'h7FC0_0001, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, 0, 0);

    // Asynchronous reset while the unit is normalising.
    while (in_ready !== 1'b1) @(negedge clk);
    a = 32'h3FC0_0000; b = 32'h3F80_0000; sub = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_state", {29'd0, in_ready, out_valid, busy}, 32'd4);
    chk("async_rst_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(32'h4000_0000, 32'h4000_0000, 1'b0, 32'h4080_0000, 4, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fp32_addsub_seq.md
Name: fp32_addsub_seq

Overview:
- Multi-cycle FP32 add/subtract unit built around one shared 8-bit exponent adder/subtractor and one 25-bit mantissa adder/subtractor.
- A state machine sequences them through ordering, alignment, add and normalisation steps.
- Sits at the accumulate side of a systolic PE, or as the shared reduction adder behind the array.
- Accepts one operation at a time over valid/ready handshakes on both input and output.

Parameters:
- EXP_W, 8, exponent width; only 8 is supported.
- MAN_W, 23, stored fraction width; only 23 is supported. Mantissa datapath is MAN_W+2 = 25 bits.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  high only in IDLE.
- a  in  32  FP32 operand A.
- b  in  32  FP32 operand B.
- sub  in  1  1: compute a-b; 0: compute a+b.
- out_valid  out  1  result valid; high only in DONE.
- out_ready  in  1  consumer accepts result.
- result  out  32  FP32 result; stable while out_valid is high.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, result=0. All internal registers clear immediately on rst_n low, including mid-operation. The operation in flight is discarded.
- Effective B sign is b[31]^sub. Denormal inputs (exp=0) are treated as zero. Rounding is truncation toward zero. No denormal outputs.
- States: IDLE, EXP, ALIGN, ADD, NORM, DONE. Transition edges below are numbered T0 (the accept edge), T1, T2, ...
- IDLE:
  - in_valid&in_ready at edge T0 latches the operands.
  - Special case, go to DONE at T0:
    - Either operand NaN, or inf plus opposite-sign inf: result 0x7FC00000.
    - Otherwise either operand inf: that inf with its effective sign.
    - Both zero: +0, or -0 if both effective signs are negative.
    - Exactly one zero: the other operand with its effective sign.
  - Otherwise go to EXP.
- EXP, edge T1:
  - Order the operands by magnitude {exp,frac} so L >= S. Equal magnitudes keep A as L.
  - diff = eL-eS via the 8-bit subtractor (Cin=1). er = eL. sign = sign of L.
- ALIGN, edge T2: mS = {1,fracS} >> diff. If diff >= 25, mS = 0. Bits shifted out are discarded.
- ADD, edge T3, 25-bit adder:
  - Same effective signs: sum = mL+mS.
  - Different effective signs: sum = mL-mS (Cin=1). Ordering guarantees sum >= 0.
  - sum == 0: result +0, go to DONE.
  - sum[24] set: shift sum right 1 and increment er. If er reaches 255, result = signed inf, go to DONE.
  - Otherwise go to NORM.
- NORM, one step per cycle:
  - m[23] set: pack {sign, er, m[22:0]}, go to DONE.
  - Otherwise, er == 1: signed zero, go to DONE (underflow).
  - Otherwise: shift m left 1, decrement er, stay.
  - At most 23 steps.
- DONE:
  - out_valid=1; result is held.
  - out_ready high: return to IDLE on that edge. in_ready rises in the following cycle.
  - in_valid is ignored outside IDLE.
- Latency (out_valid high after edge):
  - Special case: T0.
  - Zero sum: T3.
  - Normal case: T4+k, where k is the number of NORM shift steps.

Decomposition:
- Shared package:
  - FP32 field widths and bit positions.
  - Constants QNAN=0x7FC00000, INF_EXP=8'hFF, EXP_BIAS=127.
  - State encoding localparams.
- Existing primitives reused: Adder_Subtractor8 (exponent difference and increment) and Adder_Subtractor25 (mantissa add/sub). No new arithmetic cells.
- Natural sub-module: fp32_special_detect. Purely combinational NaN/inf/zero classification of a,b and the special-case result; its outputs are registered by the FSM.

Test Plan:
- Add 0x3F800000 + 0x3F800000, sub=0 -> result 0x40000000. out_valid high after T4. in_ready low T0..DONE.
- Subtract 0x3FC00000 - 0x3F800000, sub=1 -> result 0x3F000000 after one NORM step (out_valid after T5). Also 0x3F800000 + 0x30800000 -> 0x3F800000 (diff >= 25, truncated).
- Exact cancellation 0x40490FDB - 0x40490FDB -> 0x00000000, out_valid after T3.
- Specials:
  - 0x7F800000 + 0xFF800000 -> 0x7FC00000 after T0.
  - 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000.
  - 0x00000000 - 0x3F800000 -> 0xBF800000.
- Backpressure: out_ready low 10 cycles in DONE -> result and out_valid stable, new in_valid ignored. out_ready high -> IDLE next edge, in_ready=1, next op accepted.
- Reset: rst_n low during NORM of 0x3FC00000 - 0x3F800000 -> outputs return to reset values immediately (not clock-gated). After release, 0x40000000 + 0x40000000 -> 0x40800000.
